mem_io_responder: RTL and testbench
===================================

// Module: mem_io_responder
// PURPOSE
//  Memory/IO responder for the LC-3 datapath's MAR/MDR bus. Services one CPU read or write
//  per request, inserts SRAM wait states, maps address IO_ADDR to switches (read) and hex
//  display register (write), and returns read data plus a one-cycle ready pulse R.
//  Sits between the CPU datapath/control FSM and the off-chip SRAM pins.
// PARAMETERS
//  WAIT_CYCLES  2         SRAM cycles with strobes asserted before data is sampled/committed (1..15)
//  IO_ADDR      16'hFFFF  address decoded as switch/hex I/O instead of SRAM
//  SRAM_AW      20        SRAM address width; CPU address zero-extended into it
// PORTS
//  Clk            in   1        system clock, all state on rising edge
//  Reset          in   1        asynchronous, active-low reset
//  MAR            in   16       access address from CPU
//  MDR            in   16       write data from CPU
//  MEM_OE         in   1        read request, level, held by CPU until R
//  MEM_WE         in   1        write request, level, held by CPU until R
//  MDR_In         out  16       read data to CPU, registered
//  R              out  1        ready, one-cycle pulse at access completion
//  Switches       in   16       board switches, read at IO_ADDR
//  HEX_Data       out  16       hex-display register, written at IO_ADDR
//  SRAM_ADDR      out  SRAM_AW  SRAM address, registered
//  SRAM_DQ_Out    out  16       SRAM write data
//  SRAM_DQ_In     in   16       SRAM read data
//  SRAM_DQ_OE     out  1        1 = drive SRAM_DQ_Out onto pad bus
//  CE_N, OE_N, WE_N out 1       SRAM strobes, active-low, registered
// BEHAVIOUR
//  - Reset (async, low): state IDLE, MDR_In=0, R=0, HEX_Data=0, SRAM_ADDR=0, SRAM_DQ_OE=0,
//    CE_N=OE_N=WE_N=1, wait counter=0. Reset mid-access abandons it; no write committed after.
//  - States: IDLE, RD_WAIT, WR_WAIT, DONE, RELEASE.
//  - IDLE: MEM_WE has priority if both requests high (treated as write). On request:
//    MAR==IO_ADDR -> read: MDR_In<=Switches; write: HEX_Data<=MDR; go DONE (R next cycle).
//    else latch MAR/MDR, CE_N=0 and OE_N=0 (read) or WE_N=0 + SRAM_DQ_OE=1 (write),
//    counter<=WAIT_CYCLES-1, go RD_WAIT/WR_WAIT.
//  - RD_WAIT/WR_WAIT: decrement counter; at 0: read samples MDR_In<=SRAM_DQ_In; strobes and
//    SRAM_DQ_OE deassert; go DONE. MAR/MDR changes during wait are ignored (latched copy used).
//  - DONE: R=1 for exactly this cycle; go RELEASE.
//  - RELEASE: wait until MEM_OE=MEM_WE=0, then IDLE. Prevents a held request re-triggering.
//  - Latency (request high at edge k in IDLE): SRAM access R at k+WAIT_CYCLES+1; I/O R at k+1.
//  - MDR_In holds last read value until next read; writes never change MDR_In.
//  - Address wrap: none; 16-bit address zero-extended, upper SRAM_AW-16 bits always 0.
//  - SRAM_DQ_OE and OE_N are never both active (no bus contention), including at transitions.
// STRUCTURE
//  - Package lc3_mem_pkg: state enum mem_state_t, IO_ADDR default constant, strobe-idle constant.
//  - One sub-module: mem_wait_counter (load/decrement/zero flag, 4-bit) used by wait states.
//  - Everything else (FSM, I/O register, output registers) in this module.
// TESTING
//  1 SRAM read: MAR=16'h3000, MEM_OE=1, SRAM_DQ_In=16'h1234, WAIT_CYCLES=2 -> OE_N/CE_N low
//    2 cycles, R pulses at k+3, MDR_In=16'h1234, SRAM_ADDR=20'h03000.
//  2 SRAM write: MAR=16'h0010, MDR=16'hBEEF, MEM_WE=1 -> WE_N low 2 cycles with SRAM_DQ_OE=1,
//    SRAM_DQ_Out=16'hBEEF; R at k+3; MDR_In unchanged.
//  3 I/O: write MAR=16'hFFFF MDR=16'h00A5 -> HEX_Data=16'h00A5, R at k+1, strobes stay high;
//    read MAR=16'hFFFF Switches=16'h0F0F -> MDR_In=16'h0F0F, R at k+1.
//  4 Held request: keep MEM_OE=1 for 10 cycles -> exactly one R pulse, one SRAM access.
//  5 Both MEM_OE=MEM_WE=1 -> write performed, OE_N stays high.
//  6 Reset low during WR_WAIT -> strobes high, SRAM_DQ_OE=0, HEX_Data=0 immediately; no R.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory/IO responder.
package lc3_mem_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_WAIT,
      ST_WR_WAIT,
      ST_DONE,
      ST_RELEASE
   } mem_state_t;

   localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

   typedef struct packed {
      logic ce_n;
      logic oe_n;
      logic we_n;
   } sram_strobe_t;

   localparam sram_strobe_t STROBE_IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1};

endpackage

// File: rtl/mem_wait_counter.sv
// 4-bit SRAM wait-state counter: load, saturating decrement, zero flag.
module mem_wait_counter
   import lc3_mem_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_load,
   input  logic [3:0] i_load_val,
   input  logic       i_dec,
   output logic       o_zero
);

   logic [3:0] r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - 4'd1;
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_io_responder.sv
// LC-3 MAR/MDR bus responder: SRAM accesses with wait states, switch/hex I/O
// at IO_ADDR, and a one-cycle ready pulse R per request.
module mem_io_responder
   import lc3_mem_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT,
   parameter int unsigned SRAM_AW     = 20
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic [15:0]        MAR,
   input  logic [15:0]        MDR,
   input  logic               MEM_OE,
   input  logic               MEM_WE,
   output logic [15:0]        MDR_In,
   output logic               R,
   input  logic [15:0]        Switches,
   output logic [15:0]        HEX_Data,
   output logic [SRAM_AW-1:0] SRAM_ADDR,
   output logic [15:0]        SRAM_DQ_Out,
   input  logic [15:0]        SRAM_DQ_In,
   output logic               SRAM_DQ_OE,
   output logic               CE_N,
   output logic               OE_N,
   output logic               WE_N
);

   localparam logic [3:0] LP_LOAD = 4'(WAIT_CYCLES - 1);

   mem_state_t          r_state, w_next;
   logic [15:0]         r_mdr_in, w_mdr_in;
   logic [15:0]         r_hex, w_hex;
   logic [SRAM_AW-1:0]  r_addr, w_addr;
   logic [15:0]         r_dq_out, w_dq_out;
   logic                r_dq_oe, w_dq_oe;
   sram_strobe_t        r_strobe, w_strobe;
   logic                w_load, w_dec, w_zero;
   logic                w_is_io;

   assign w_is_io = (MAR == IO_ADDR);

   mem_wait_counter u_wait (
      .i_clk      (Clk),
      .i_rst_n    (Reset),
      .i_load     (w_load),
      .i_load_val (LP_LOAD),
      .i_dec      (w_dec),
      .o_zero     (w_zero)
   );

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (MEM_WE) begin
               w_next = w_is_io ? ST_DONE : ST_WR_WAIT;
            end else if (MEM_OE) begin
               w_next = w_is_io ? ST_DONE : ST_RD_WAIT;
            end
         end
         ST_RD_WAIT, ST_WR_WAIT: begin
            if (w_zero) begin
               w_next = ST_DONE;
            end
         end
         ST_DONE:    w_next = ST_RELEASE;
         ST_RELEASE: begin
            if (!MEM_OE && !MEM_WE) begin
               w_next = ST_IDLE;
            end
         end
         default:    w_next = ST_IDLE;
      endcase
   end

   // Next values for the registered outputs; read and write paths never
   // enable OE_N and SRAM_DQ_OE together, and both drop on the same edge.
   always_comb begin
      w_mdr_in = r_mdr_in;
      w_hex    = r_hex;
      w_addr   = r_addr;
      w_dq_out = r_dq_out;
      w_dq_oe  = r_dq_oe;
      w_strobe = r_strobe;
      w_load   = 1'b0;
      w_dec    = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (MEM_WE) begin
               if (w_is_io) begin
                  w_hex = MDR;
               end else begin
                  w_addr        = SRAM_AW'(MAR);
                  w_dq_out      = MDR;
                  w_dq_oe       = 1'b1;
                  w_strobe.ce_n = 1'b0;
                  w_strobe.we_n = 1'b0;
                  w_load        = 1'b1;
               end
            end else if (MEM_OE) begin
               if (w_is_io) begin
                  w_mdr_in = Switches;
               end else begin
                  w_addr        = SRAM_AW'(MAR);
                  w_strobe.ce_n = 1'b0;
                  w_strobe.oe_n = 1'b0;
                  w_load        = 1'b1;
               end
            end
         end
         ST_RD_WAIT: begin
            if (w_zero) begin
               w_mdr_in = SRAM_DQ_In;
               w_strobe = STROBE_IDLE;
            end else begin
               w_dec = 1'b1;
            end
         end
         ST_WR_WAIT: begin
            if (w_zero) begin
               w_strobe = STROBE_IDLE;
               w_dq_oe  = 1'b0;
            end else begin
               w_dec = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_mdr_in <= '0;
         r_hex    <= '0;
         r_addr   <= '0;
         r_dq_out <= '0;
         r_dq_oe  <= 1'b0;
         r_strobe <= STROBE_IDLE;
      end else begin
         r_mdr_in <= w_mdr_in;
         r_hex    <= w_hex;
         r_addr   <= w_addr;
         r_dq_out <= w_dq_out;
         r_dq_oe  <= w_dq_oe;
         r_strobe <= w_strobe;
      end
   end

   assign MDR_In      = r_mdr_in;
   assign R           = (r_state == ST_DONE);
   assign HEX_Data    = r_hex;
   assign SRAM_ADDR   = r_addr;
   assign SRAM_DQ_Out = r_dq_out;
   assign SRAM_DQ_OE  = r_dq_oe;
   assign CE_N        = r_strobe.ce_n;
   assign OE_N        = r_strobe.oe_n;
   assign WE_N        = r_strobe.we_n;

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: transaction-timestamp model checked every cycle,
// plus directed accesses with hand-computed expectations.
module tb_mem_io_responder;

   localparam int unsigned W   = 2;
   localparam logic [15:0] IOA = 16'hFFFF;

   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic [15:0] MAR = '0, MDR = '0, Switches = '0, SRAM_DQ_In = '0;
   logic        MEM_OE = 1'b0, MEM_WE = 1'b0;
   logic [15:0] MDR_In, HEX_Data, SRAM_DQ_Out;
   logic [19:0] SRAM_ADDR;
   logic        R, SRAM_DQ_OE, CE_N, OE_N, WE_N;

   mem_io_responder #(
      .WAIT_CYCLES (W),
      .IO_ADDR     (IOA),
      .SRAM_AW     (20)
   ) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .MAR         (MAR),
      .MDR         (MDR),
      .MEM_OE      (MEM_OE),
      .MEM_WE      (MEM_WE),
      .MDR_In      (MDR_In),
      .R           (R),
      .Switches    (Switches),
      .HEX_Data    (HEX_Data),
      .SRAM_ADDR   (SRAM_ADDR),
      .SRAM_DQ_Out (SRAM_DQ_Out),
      .SRAM_DQ_In  (SRAM_DQ_In),
      .SRAM_DQ_OE  (SRAM_DQ_OE),
      .CE_N        (CE_N),
      .OE_N        (OE_N),
      .WE_N        (WE_N)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: one transaction at a time, described by its start edge and the
   // edge after which R is visible; everything else follows from those.
   int          e = 0;
   bit          m_busy = 0, m_wr = 0, m_io = 0;
   int          m_start = 0, m_end = 0;
   logic [15:0] m_mdr_in = '0, m_hex = '0, m_dq_out = '0;
   logic [19:0] m_addr = '0;

   always @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         m_busy   = 0;
         m_mdr_in = '0;
         m_hex    = '0;
         m_addr   = '0;
      end else begin
         e++;
         if (!m_busy) begin
            if (MEM_OE || MEM_WE) begin
               m_busy  = 1;
               m_wr    = MEM_WE;
               m_io    = (MAR == IOA);
               m_start = e;
               if (m_io) begin
                  m_end = e;
                  if (m_wr) m_hex = MDR;
                  else      m_mdr_in = Switches;
               end else begin
                  m_end  = e + int'(W);
                  m_addr = {4'h0, MAR};
                  if (m_wr) m_dq_out = MDR;
               end
            end
         end else begin
            if (!m_wr && !m_io && e == m_end) m_mdr_in = SRAM_DQ_In;
            if (e >= m_end + 2 && !MEM_OE && !MEM_WE) m_busy = 0;
         end
      end
   end

   int obs_r = 0, obs_ce = 0, obs_oe = 0, obs_we = 0;
   bit win;

   always @(negedge Clk) begin
      if (Reset) begin
         win = m_busy && !m_io && (e >= m_start) && (e < m_end);
         chk("R",           R,           (m_busy && e == m_end));
         chk("CE_N",        CE_N,        !win);
         chk("OE_N",        OE_N,        !(win && !m_wr));
         chk("WE_N",        WE_N,        !(win && m_wr));
         chk("SRAM_DQ_OE",  SRAM_DQ_OE,  (win && m_wr));
         chk("MDR_In",      MDR_In,      m_mdr_in);
         chk("HEX_Data",    HEX_Data,    m_hex);
         chk("SRAM_ADDR",   SRAM_ADDR,   m_addr);
         chk("bus_contention", (!OE_N && SRAM_DQ_OE), 1'b0);
         if (win && m_wr) chk("SRAM_DQ_Out", SRAM_DQ_Out, m_dq_out);
         obs_r  += int'(R);
         obs_ce += int'(!CE_N);
         obs_oe += int'(!OE_N);
         obs_we += int'(!WE_N);
      end
   end

   task automatic access(input logic we, input logic oe, input logic [15:0] mar,
                         input logic [15:0] mdr, input logic [15:0] dq, input logic [15:0] sw,
                         output int lat, output int ce_cyc, output int oe_cyc, output int we_cyc);
      int c0, o0, w0;
      @(negedge Clk);
      c0 = obs_ce; o0 = obs_oe; w0 = obs_we;
      MAR = mar; MDR = mdr; SRAM_DQ_In = dq; Switches = sw;
      MEM_WE = we; MEM_OE = oe;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge Clk);
         if (i == 1) begin
            MAR = ~mar;
            MDR = ~mdr;
         end
         if (R === 1'b1) begin
            lat = i;
            break;
         end
      end
      MEM_WE = 1'b0;
      MEM_OE = 1'b0;
      repeat (3) @(negedge Clk);
      ce_cyc = obs_ce - c0;
      oe_cyc = obs_oe - o0;
      we_cyc = obs_we - w0;
   endtask

   int lat, ce_c, oe_c, we_c, r0, c0, w0;

   initial begin
      repeat (3) @(negedge Clk);
      chk("rst_R",         R,          1'b0);
      chk("rst_CE_N",      CE_N,       1'b1);
      chk("rst_OE_N",      OE_N,       1'b1);
      chk("rst_WE_N",      WE_N,       1'b1);
      chk("rst_DQ_OE",     SRAM_DQ_OE, 1'b0);
      chk("rst_MDR_In",    MDR_In,     16'h0000);
      chk("rst_HEX",       HEX_Data,   16'h0000);
      chk("rst_SRAM_ADDR", SRAM_ADDR,  20'h00000);
      #2 Reset = 1'b1;
      repeat (2) @(negedge Clk);

      // SRAM read
      access(1'b0, 1'b1, 16'h3000, 16'h0000, 16'h1234, 16'h0000, lat, ce_c, oe_c, we_c);
      chk("t1_latency",  lat,       32'd3);
      chk("t1_ce_cyc",   ce_c,      32'd2);
      chk("t1_oe_cyc",   oe_c,      32'd2);
      chk("t1_we_cyc",   we_c,      32'd0);
      chk("t1_MDR_In",   MDR_In,    16'h1234);
      chk("t1_ADDR",     SRAM_ADDR, 20'h03000);

      // SRAM write
      access(1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h9999, 16'h0000, lat, ce_c, oe_c, we_c);
      chk("t2_latency",  lat,       32'd3);
      chk("t2_we_cyc",   we_c,      32'd2);
      chk("t2_oe_cyc",   oe_c,      32'd0);
      chk("t2_MDR_In",   MDR_In,    16'h1234);
      chk("t2_ADDR",     SRAM_ADDR, 20'h00010);

      // I/O write then read
      access(1'b1, 1'b0, 16'hFFFF, 16'h00A5, 16'h0000, 16'h0000, lat, ce_c, oe_c, we_c);
      chk("t3w_latency", lat,       32'd1);
      chk("t3w_ce_cyc",  ce_c,      32'd0);
      chk("t3w_HEX",     HEX_Data,  16'h00A5);
      access(1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 16'h0F0F, lat, ce_c, oe_c, we_c);
      chk("t3r_latency", lat,       32'd1);
      chk("t3r_ce_cyc",  ce_c,      32'd0);
      chk("t3r_MDR_In",  MDR_In,    16'h0F0F);

      // Held read request
      @(negedge Clk);
      r0 = obs_r; c0 = obs_ce;
      MAR = 16'h3004; SRAM_DQ_In = 16'h5A5A; MEM_OE = 1'b1;
      repeat (10) @(negedge Clk);
      MEM_OE = 1'b0;
      repeat (3) @(negedge Clk);
      chk("t4_r_pulses", obs_r - r0,  32'd1);
      chk("t4_ce_cyc",   obs_ce - c0, 32'd2);
      chk("t4_MDR_In",   MDR_In,      16'h5A5A);

      // Both requests: treated as write
      access(1'b1, 1'b1, 16'h0040, 16'hCAFE, 16'h7777, 16'h0000, lat, ce_c, oe_c, we_c);
      chk("t5_latency",  lat,       32'd3);
      chk("t5_oe_cyc",   oe_c,      32'd0);
      chk("t5_we_cyc",   we_c,      32'd2);
      chk("t5_MDR_In",   MDR_In,    16'h5A5A);

      // Reset during WR_WAIT
      @(negedge Clk);
      MAR = 16'h0020; MDR = 16'h1111; MEM_WE = 1'b1;
      @(negedge Clk);
      chk("t6_pre_WE_N", WE_N, 1'b0);
      #2 Reset = 1'b0;
      #1;
      chk("t6_CE_N",     CE_N,       1'b1);
      chk("t6_WE_N",     WE_N,       1'b1);
      chk("t6_DQ_OE",    SRAM_DQ_OE, 1'b0);
      chk("t6_HEX",      HEX_Data,   16'h0000);
      chk("t6_R",        R,          1'b0);
      MEM_WE = 1'b0;
      r0 = obs_r; w0 = obs_we;
      @(negedge Clk);
      #2 Reset = 1'b1;
      repeat (6) @(negedge Clk);
      chk("t6_no_R",     obs_r - r0,  32'd0);
      chk("t6_no_write", obs_we - w0, 32'd0);
      chk("t6_MDR_In",   MDR_In,      16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
